ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver and successor of the current keyboard block. It runs in a single clock domain and filters glitches on ps2_clk. A frame FSM checks start, odd parity and stop, and a watchdog aborts stalled frames. Valid scan codes are buffered in a full-depth FWFT FIFO that the CPU bus logic reads.

Parameters:
DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (all usable; no sacrificed slot)
FILTER_LEN, 4, consecutive equal synchronised samples required to change the filtered ps2_clk level (>=2)
TIMEOUT, 50000, clk cycles without a falling edge before an in-progress frame is aborted (1 ms at 50 MHz)

Ports:
clk  in  1  system clock; one clock; reset is synchronous and active-high
rst  in  1  synchronous reset, active-high
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_data  in  1  raw PS/2 data (asynchronous)
rd  in  1  pop head entry; one-cycle pulse, active-high
data  out  DW  head-of-FIFO entry, valid while ready=1 (DW=8, or 10 with PS2_KBD_TAG_EN)
ready  out  1  FIFO not empty
count  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
overflow  out  1  sticky: a valid code was dropped because the FIFO was full
err_parity  out  1  sticky: frame discarded due to a parity mismatch
err_frame  out  1  sticky: bad stop bit or watchdog abort
clr_err  in  1  clears overflow, err_parity and err_frame

Behaviour:
- Reset: FSM=IDLE; FIFO empty; ready=0; count=0; all sticky flags 0; filtered clock=1; filter and watchdog counters 0; tag prefixes cleared.
- Input path: ps2_clk and ps2_data each pass through 2 FFs. The filtered clock takes the synchronised level after FILTER_LEN consecutive equal samples. A 1->0 transition of the filtered clock produces a one-cycle sample strobe. ps2_data is read in the same cycle as the strobe.
- FSM states IDLE, DATA, PARITY, STOP, clocked on the strobe:
  - IDLE: data=0 moves to DATA with bit index 0. data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift in LSB first. After bit 7 go to PARITY.
  - PARITY: latch the bit and go to STOP.
  - STOP: if stop=1 and ^{byte,parity}=1, the byte is valid. If stop=0, set err_frame. Else if parity is bad, set err_parity. In every case return to IDLE.
- Watchdog: the counter is cleared on every strobe and while in IDLE. Outside IDLE, reaching TIMEOUT-1 forces IDLE, sets err_frame and discards partial bits.
- Push: a valid byte is pushed in the cycle after the STOP strobe. ready rises on the following cycle (2 clk after the strobe).
- FIFO pointers carry an extra wrap bit, so full means count==2**DEPTH_LOG2.
  - A push while full is dropped and sets overflow.
  - A push and rd in the same cycle while full: both succeed and count is unchanged.
  - rd while empty is ignored.
  - A simultaneous push and pop on any non-full FIFO leaves count unchanged.
  - data is combinational from the head entry (FWFT). rd advances the head on the next edge.
- Sticky flags: clr_err clears all three. A new error in the same cycle as clr_err wins and the flag stays 1.
- rst mid-frame: the frame is lost, the FIFO is flushed and no flag is set.

Optional Feature:
PS2_KBD_TAG_EN
- Defined:
  - DW=10 and entries are {brk, ext, code[7:0]}.
  - Byte 8'hE0 sets ext_pend and byte 8'hF0 sets brk_pend. Prefix bytes are not pushed.
  - The next non-prefix byte is pushed with the pending flags, then both flags are cleared.
  - A frame error, watchdog abort or overflow drop also clears the pending flags.
- Undefined: DW=8 and every valid byte is pushed raw, with no prefix logic.

Decomposition:
- Package ps2_pkg holds:
  - the FSM state enum
  - DW, defined as 10 or 8 under the macro
  - PS2_EXT=8'hE0 and PS2_BRK=8'hF0
- One sub-module, ps2_sync_filter, provides the 2-FF synchronisers, the FILTER_LEN filter and the falling-edge strobe. Its outputs are fall_stb and data_s.

Test Plan:
- Send valid frame for 8'h1C (parity 0, stop 1) -> ready=1 two clk after the stop strobe, data=8'h1C, count=1; one rd pulse -> ready=0, count=0.
- Push 8 codes 8'h01..8'h08 with no reads at DEPTH_LOG2=3, then send 8'h09 -> count=8, overflow=1, reads return 8'h01..8'h08 in order; repeat with rd asserted in the push cycle -> 8'h09 accepted, overflow stays 0.
- Frame 8'h1C with parity bit 1 -> nothing pushed, err_parity=1. Frame with stop=0 -> err_frame=1. clr_err pulse -> all flags 0.
- Stop ps2_clk after 4 data bits for >TIMEOUT cycles -> FSM back in IDLE, err_frame=1; the next valid frame 8'h2A is received correctly.
- Inject 1-cycle ps2_clk glitches (< FILTER_LEN) during a frame -> no extra strobes, byte 8'h5A received intact.
- With PS2_KBD_TAG_EN, send E0 F0 75 -> single entry 10'b11_0111_0101; send F0 1C -> 10'b10_0001_1100; send 1C -> 10'b00_0001_1100.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_t : frame FSM states
//   DW          : FIFO entry width (10 with PS2_KBD_TAG_EN defined, else 8)
//   PS2_EXT     : extended-key prefix byte
//   PS2_BRK     : break (key release) prefix byte
// Configuration macro: PS2_KBD_TAG_EN
package ps2_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StData   = 2'd1,
      StParity = 2'd2,
      StStop   = 2'd3
   } ps2_state_t;

`ifdef PS2_KBD_TAG_EN
   localparam int DW = 10;
`else
   localparam int DW = 8;
`endif

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: input conditioning for the PS/2 lines.
//   clk, rst : system clock, synchronous active-high reset
//   ps2_clk  : raw PS/2 clock (asynchronous)
//   ps2_data : raw PS/2 data (asynchronous)
//   fall_stb : one-cycle pulse on each 1->0 transition of the filtered clock
//   data_s   : synchronised PS/2 data
module ps2_sync_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall_stb,
   output logic data_s
);

   localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          clk_f;
   logic [CW-1:0] flt_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_f     <= 1'b1;
         flt_cnt   <= '0;
         fall_stb  <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         fall_stb  <= 1'b0;
         // Any sample equal to the filtered level restarts the run count.
         if (clk_sync[1] == clk_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == CNT_MAX) begin
            clk_f    <= clk_sync[1];
            flt_cnt  <= '0;
            fall_stb <= clk_f;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with glitch filter, frame FSM, watchdog and FWFT FIFO.
//   clk, rst   : system clock, synchronous active-high reset
//   ps2_clk    : raw PS/2 clock
//   ps2_data   : raw PS/2 data
//   rd         : pop the head entry (one-cycle pulse)
//   data       : head-of-FIFO entry, valid while ready=1
//   ready      : FIFO not empty
//   count      : FIFO occupancy 0..2**DEPTH_LOG2
//   overflow   : sticky, valid code dropped on a full FIFO
//   err_parity : sticky, frame dropped on parity mismatch
//   err_frame  : sticky, bad stop bit or watchdog abort
//   clr_err    : clears the three sticky flags
// Configuration macro: PS2_KBD_TAG_EN (entries become {brk, ext, code}).
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   input  logic                rd,
   output logic [DW-1:0]       data,
   output logic                ready,
   output logic [DEPTH_LOG2:0] count,
   output logic                overflow,
   output logic                err_parity,
   output logic                err_frame,
   input  logic                clr_err
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int WW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

   logic fall_stb;
   logic data_s;

   ps2_sync_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_filt (
      .clk     (clk),
      .rst     (rst),
      .ps2_clk (ps2_clk),
      .ps2_data(ps2_data),
      .fall_stb(fall_stb),
      .data_s  (data_s)
   );

   ps2_state_t    state_q, state_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic [WW-1:0] wd_q, wd_d;
   logic          push_q, push_d;
   logic [DW-1:0] push_data_q, push_data_d;
   logic          set_par, set_frm;
`ifdef PS2_KBD_TAG_EN
   logic          ext_q, ext_d, brk_q, brk_d;
`endif

   always_comb begin
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      par_d       = par_q;
      push_d      = 1'b0;
      push_data_d = push_data_q;
      set_par     = 1'b0;
      set_frm     = 1'b0;
      wd_d        = (state_q == StIdle) ? '0 : wd_q + 1'b1;
`ifdef PS2_KBD_TAG_EN
      ext_d       = ext_q;
      brk_d       = brk_q;
`endif
      if (fall_stb) begin
         wd_d = '0;
         case (state_q)
            StIdle: begin
               if (!data_s) begin
                  state_d   = StData;
                  bit_idx_d = 3'd0;
               end
            end
            StData: begin
               shreg_d   = {data_s, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = StParity;
            end
            StParity: begin
               par_d   = data_s;
               state_d = StStop;
            end
            StStop: begin
               state_d = StIdle;
               if (!data_s) begin
                  set_frm = 1'b1;
               end else if (!(^{shreg_q, par_q})) begin
                  set_par = 1'b1;
               end else begin
`ifdef PS2_KBD_TAG_EN
                  if (shreg_q == PS2_EXT) begin
                     ext_d = 1'b1;
                  end else if (shreg_q == PS2_BRK) begin
                     brk_d = 1'b1;
                  end else begin
                     push_d      = 1'b1;
                     push_data_d = {brk_q, ext_q, shreg_q};
                     ext_d       = 1'b0;
                     brk_d       = 1'b0;
                  end
`else
                  push_d      = 1'b1;
                  push_data_d = shreg_q;
`endif
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (state_q != StIdle && wd_q == WD_MAX) begin
         state_d = StIdle;
         set_frm = 1'b1;
      end
`ifdef PS2_KBD_TAG_EN
      // Pending flags are already consumed when an entry is formed, so an
      // overflow drop needs no extra clearing here.
      if (set_frm) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         par_q       <= 1'b0;
         wd_q        <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
`ifdef PS2_KBD_TAG_EN
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         par_q       <= par_d;
         wd_q        <= wd_d;
         push_q      <= push_d;
         push_data_q <= push_data_d;
`ifdef PS2_KBD_TAG_EN
         ext_q       <= ext_d;
         brk_q       <= brk_d;
`endif
      end
   end

   // FIFO: pointers carry a wrap bit so all DEPTH slots are usable.
   logic [DW-1:0]       mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
   logic                full, do_push, do_pop, drop;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
   assign ready   = (count != '0);
   assign do_pop  = rd & ready;
   // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
   assign do_push = push_q & (~full | rd);
   assign drop    = push_q & full & ~rd;
   assign data    = mem[rd_ptr[DEPTH_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow   <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         // A new error in the clearing cycle keeps the flag set.
         overflow   <= (overflow & ~clr_err) | drop;
         err_parity <= (err_parity & ~clr_err) | set_par;
         err_frame  <= (err_frame & ~clr_err) | set_frm;
      end
   end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed self-checking bench for ps2_kbd_rx.
// Runs the tag-prefix steps only when PS2_KBD_TAG_EN is defined.
module tb_ps2_kbd_rx;
   import ps2_pkg::*;

   localparam int DEPTH_LOG2 = 3;
   localparam int FILTER_LEN = 4;
   localparam int TIMEOUT    = 300;

   logic                clk = 1'b0;
   logic                rst, ps2_clk, ps2_data, rd, clr_err;
   logic [DW-1:0]       data;
   logic                ready, overflow, err_parity, err_frame;
   logic [DEPTH_LOG2:0] count;

   int n_pass  = 0;
   int n_total = 0;
   int stb_cnt = 0;

   ps2_kbd_rx #(
      .DEPTH_LOG2(DEPTH_LOG2),
      .FILTER_LEN(FILTER_LEN),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd        (rd),
      .data      (data),
      .ready     (ready),
      .count     (count),
      .overflow  (overflow),
      .err_parity(err_parity),
      .err_frame (err_frame),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (dut.fall_stb) stb_cnt <= stb_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One PS/2 bit: data set while clock high, then a low phase. Optional
   // single-cycle glitches in both phases; hold_low stops after the falling edge.
   task automatic send_bit(input logic v, input bit glitch, input bit hold_low);
      @(negedge clk) ps2_data = v;
      if (glitch) begin
         repeat (6) @(negedge clk);
         ps2_clk = 1'b0;
         @(negedge clk) ps2_clk = 1'b1;
         repeat (3) @(negedge clk);
      end else begin
         repeat (10) @(negedge clk);
      end
      ps2_clk = 1'b0;
      if (hold_low) return;
      if (glitch) begin
         repeat (7) @(negedge clk);
         ps2_clk = 1'b1;
         @(negedge clk) ps2_clk = 1'b0;
         repeat (2) @(negedge clk);
      end else begin
         repeat (10) @(negedge clk);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                             input bit glitch);
      logic [10:0] f;
      f = {stop, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(f[i], glitch, 1'b0);
      repeat (10) @(negedge clk);
      ps2_data = 1'b1;
   endtask

   // Bits 0..9 of a valid frame, then the stop bit's falling edge held low.
   task automatic send_to_stop(input logic [7:0] b);
      logic [10:0] f;
      f = {1'b1, ~^b, b, 1'b0};
      for (int i = 0; i < 10; i++) send_bit(f[i], 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b1);
   endtask

   task automatic wait_stb(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dut.fall_stb) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
      chk(tag, 32'(data), 32'(exp));
      rd = 1'b1;
      @(negedge clk) rd = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
   endtask

   initial begin
      bit ok;
      int s0;
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0; clr_err = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_ready", 32'(ready), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_epar", 32'(err_parity), 0);
      chk("rst_efrm", 32'(err_frame), 0);
      chk("rst_state", 32'(dut.state_q), 32'(StIdle));

      // Single frame 1C with push latency
      send_to_stop(8'h1C);
      wait_stb(ok);
      chk("stop_stb_seen", 32'(ok), 1);
      @(negedge clk);
      chk("ready_stb_plus1", 32'(ready), 0);
      @(negedge clk);
      chk("ready_stb_plus2", 32'(ready), 1);
      chk("count_one", 32'(count), 1);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
      ps2_data = 1'b1;
      pop_chk("data_1c", 8'h1C);
      chk("ready_after_rd", 32'(ready), 0);
      chk("count_after_rd", 32'(count), 0);
      rd = 1'b1;
      @(negedge clk) rd = 1'b0;
      chk("rd_empty_count", 32'(count), 0);

      // Fill, then overflow
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      chk("full_count", 32'(count), 8);
      chk("full_no_ovf", 32'(overflow), 0);
      send_frame(8'h09, 1'b0, 1'b1, 1'b0);
      chk("ovf_count", 32'(count), 8);
      chk("ovf_set", 32'(overflow), 1);
      for (int i = 1; i <= 8; i++) pop_chk($sformatf("ovf_rd%0d", i), DW'(i));
      chk("ovf_drained", 32'(count), 0);

      // Fill again; push while full with rd in the push cycle
      pulse_clr();
      chk("ovf_cleared", 32'(overflow), 0);
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      send_to_stop(8'h09);
      wait_stb(ok);
      chk("stb_09_seen", 32'(ok), 1);
      @(negedge clk) rd = 1'b1;
      @(negedge clk) rd = 1'b0;
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
      ps2_data = 1'b1;
      chk("pushpop_count", 32'(count), 8);
      chk("pushpop_no_ovf", 32'(overflow), 0);
      for (int i = 2; i <= 9; i++) pop_chk($sformatf("pp_rd%0d", i), DW'(i));
      chk("pp_drained", 32'(count), 0);

      // Parity error, stop error, clear
      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      chk("par_count", 32'(count), 0);
      chk("par_flag", 32'(err_parity), 1);
      chk("par_no_frm", 32'(err_frame), 0);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      chk("stop_count", 32'(count), 0);
      chk("stop_flag", 32'(err_frame), 1);
      pulse_clr();
      chk("clr_ovf", 32'(overflow), 0);
      chk("clr_par", 32'(err_parity), 0);
      chk("clr_frm", 32'(err_frame), 0);

      // Watchdog: start + 4 data bits then stall
      send_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
      @(negedge clk) ps2_data = 1'b1;
      chk("wd_mid_state", 32'(dut.state_q), 32'(StData));
      chk("wd_mid_frm", 32'(err_frame), 0);
      repeat (TIMEOUT + 20) @(negedge clk);
      chk("wd_state_idle", 32'(dut.state_q), 32'(StIdle));
      chk("wd_frm", 32'(err_frame), 1);
      chk("wd_count", 32'(count), 0);
      pulse_clr();
      send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
      chk("wd_next_count", 32'(count), 1);
      pop_chk("wd_next_data", 8'h2A);
      chk("wd_next_frm", 32'(err_frame), 0);

      // Glitch immunity
      s0 = stb_cnt;
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      chk("glitch_stbs", 32'(stb_cnt - s0), 11);
      chk("glitch_count", 32'(count), 1);
      chk("glitch_par", 32'(err_parity), 0);
      chk("glitch_frm", 32'(err_frame), 0);
      pop_chk("glitch_data", 8'h5A);

      // Reset mid-frame flushes the FIFO and sets no flag
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      ps2_data = 1'b1;
      @(negedge clk);
      chk("mrst_count", 32'(count), 0);
      chk("mrst_ready", 32'(ready), 0);
      chk("mrst_state", 32'(dut.state_q), 32'(StIdle));
      chk("mrst_flags", 32'({overflow, err_parity, err_frame}), 0);
      send_frame(8'h33, 1'b0, 1'b1, 1'b0);
      chk("mrst_next_count", 32'(count), 1);
      pop_chk("mrst_next_data", 8'h33);

`ifdef PS2_KBD_TAG_EN
      send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      chk("tag_prefix_none", 32'(count), 0);
      send_frame(8'h75, 1'b0, 1'b1, 1'b0);
      chk("tag_e0f075_count", 32'(count), 1);
      pop_chk("tag_e0f075", 10'h375);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk("tag_f01c_count", 32'(count), 1);
      pop_chk("tag_f01c", 10'h21C);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk("tag_1c_count", 32'(count), 1);
      pop_chk("tag_1c", 10'h01C);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
